// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared types and constants.
// FSM encoding and latency counter sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/acknowledge bus.
// master = CPU memory stage, slave = responder.
interface dmem_responder_if;

  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output wdata_i,
    input  busy_o,
    input  ack_o,
    input  err_o,
    input  rdata_o
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  wdata_i,
    output busy_o,
    output ack_o,
    output err_o,
    output rdata_o
  );

endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 word storage.
// Synchronous write, registered synchronous read, no reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  // write port
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  // registered read port, holds between reads
  always_ff @(posedge clk_i) begin
    if (re_i) r_q <= r_mem[raddr_i];
  end

  assign rdata_o = r_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder.
// Fixed latency, one transaction in flight, zero-bubble reissue.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_to_resp;
  logic             w_illegal;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [31:0]      w_q;

  assign w_illegal = (r_addr[1:0] != 2'b00) ||
                     ((r_addr >> (AW + 2)) != 32'd0);
  assign w_wr_en   = w_to_resp && r_we && !w_illegal;
  assign w_wr_idx  = r_addr[AW+1:2];
  assign w_rd_idx  = bus.addr_i[AW+1:2];

  // read on acceptance so data is ready by the RESP edge
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_wr_en),
    .waddr_i (w_wr_idx),
    .wdata_i (r_wdata),
    .re_i    (w_accept),
    .raddr_i (w_rd_idx),
    .rdata_o (w_q)
  );

  // next state, counter and acceptance; RESP accepts like IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_to_resp   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = LAT_M1;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_to_resp   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        if (bus.req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = LAT_M1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, request capture and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= 1'b0;
      if (w_accept) begin
        r_we    <= bus.we_i;
        r_addr  <= bus.addr_i;
        r_wdata <= bus.wdata_i;
      end
      if (w_to_resp) begin
        r_err <= w_illegal;
        if (w_illegal) r_rdata <= '0;
        else if (!r_we) r_rdata <= w_q;
      end
    end
  end

  assign bus.busy_o  = (r_state != IDLE);
  assign bus.ack_o   = (r_state == RESP);
  assign bus.err_o   = r_err;
  assign bus.rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Unit A: LATENCY=3, unit B: LATENCY=1.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_responder_if bus_a();
  dmem_responder_if bus_b();

  dmem_responder #(
    .DEPTH   (256),
    .LATENCY (3)
  ) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  dmem_responder #(
    .DEPTH   (256),
    .LATENCY (1)
  ) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // one transaction on unit A; returns response and edges to ack
  task automatic do_txn(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic        err,
    output logic [31:0] rd,
    output int          lat
  );
    @(negedge clk);
    bus_a.req_i   = 1'b1;
    bus_a.we_i    = we;
    bus_a.addr_i  = a;
    bus_a.wdata_i = d;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_i = 1'b0;
    lat = 0;
    while (!bus_a.ack_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    err = bus_a.err_o;
    rd  = bus_a.rdata_o;
  endtask

  task automatic test_reset();
    bus_a.req_i = 1'b0; bus_a.we_i = 1'b0;
    bus_a.addr_i = '0;  bus_a.wdata_i = '0;
    bus_b.req_i = 1'b0; bus_b.we_i = 1'b0;
    bus_b.addr_i = '0;  bus_b.wdata_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bus_a.busy_o);
    end
    checks++;
    if (bus_a.ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %b exp 0", bus_a.ack_o);
    end
    checks++;
    if (bus_a.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b exp 0", bus_a.err_o);
    end
    checks++;
    if (bus_a.rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 0", bus_a.rdata_o);
    end
    checks++;
    if (bus_b.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_b got %b exp 0", bus_b.busy_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    logic        eb, ea, err;
    logic [31:0] rd;
    int          lat;
    @(negedge clk);
    checks++;
    if (bus_a.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL st_idle_busy got %b exp 0", bus_a.busy_o);
    end
    bus_a.req_i   = 1'b1;
    bus_a.we_i    = 1'b1;
    bus_a.addr_i  = 32'h10;
    bus_a.wdata_i = 32'hDEADBEEF;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_a.req_i = 1'b0;
      eb = (i < 4);
      ea = (i == 3);
      checks++;
      if (bus_a.busy_o !== eb) begin
        errors++;
        $display("FAIL st_busy[%0d] got %b exp %b",
                 i, bus_a.busy_o, eb);
      end
      checks++;
      if (bus_a.ack_o !== ea) begin
        errors++;
        $display("FAIL st_ack[%0d] got %b exp %b",
                 i, bus_a.ack_o, ea);
      end
      if (ea) begin
        checks++;
        if (bus_a.err_o !== 1'b0) begin
          errors++;
          $display("FAIL st_err got %b exp 0", bus_a.err_o);
        end
      end
    end
    do_txn(1'b0, 32'h10, 32'h0, err, rd, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL ld_lat got %0d exp 3", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ld_data got %h exp deadbeef", rd);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL ld_err got %b exp 0", err);
    end
  endtask

  task automatic test_misaligned();
    logic        err;
    logic [31:0] rd;
    int          lat;
    do_txn(1'b0, 32'h12, 32'h0, err, rd, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL mis_lat got %0d exp 3", lat);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL mis_err got %b exp 1", err);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL mis_rdata got %h exp 0", rd);
    end
    @(negedge clk);
    checks++;
    if (bus_a.err_o !== 1'b0) begin
      errors++;
      $display("FAIL mis_err_drop got %b exp 0", bus_a.err_o);
    end
    checks++;
    if (bus_a.rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL mis_hold got %h exp 0", bus_a.rdata_o);
    end
    do_txn(1'b0, 32'h10, 32'h0, err, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mis_reload got %h exp deadbeef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic        err;
    logic [31:0] rd;
    int          lat;
    do_txn(1'b1, 32'h0, 32'h0BADF00D, err, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL oor_st_hold got %h exp deadbeef", rd);
    end
    do_txn(1'b1, 32'h400, 32'h12345678, err, rd, lat);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL oor_err got %b exp 1", err);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_rdata got %h exp 0", rd);
    end
    do_txn(1'b0, 32'h0, 32'h0, err, rd, lat);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL oor_word0 got %h exp 0badf00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int first = -1;
    int prev = -1;
    int gap_bad = 0;
    @(negedge clk);
    bus_a.req_i  = 1'b1;
    bus_a.we_i   = 1'b0;
    bus_a.addr_i = 32'h10;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.ack_o) begin
        n++;
        if (first < 0) first = i;
        if (prev >= 0 && (i - prev) != 4) gap_bad++;
        prev = i;
        checks++;
        if (bus_a.rdata_o !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL b2b_data[%0d] got %h exp deadbeef",
                   i, bus_a.rdata_o);
        end
      end
      if (i == 11) bus_a.req_i = 1'b0;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", n);
    end
    checks++;
    if (first !== 3) begin
      errors++;
      $display("FAIL b2b_first got %0d exp 3", first);
    end
    checks++;
    if (gap_bad !== 0) begin
      errors++;
      $display("FAIL b2b_gap bad %0d exp 0", gap_bad);
    end
  endtask

  task automatic test_latency1();
    int n = 0;
    int a0 = -1;
    int a1 = -1;
    @(negedge clk);
    bus_b.req_i   = 1'b1;
    bus_b.we_i    = 1'b1;
    bus_b.addr_i  = 32'h20;
    bus_b.wdata_i = 32'hCAFEF00D;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_b.ack_o) begin
        n++;
        if (a0 < 0) a0 = i;
        else if (a1 < 0) begin
          a1 = i;
          checks++;
          if (bus_b.rdata_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL l1_data got %h exp cafef00d",
                     bus_b.rdata_o);
          end
          checks++;
          if (bus_b.err_o !== 1'b0) begin
            errors++;
            $display("FAIL l1_err got %b exp 0", bus_b.err_o);
          end
        end
      end
      if (i == 0) bus_b.we_i = 1'b0;
      if (i == 2) bus_b.req_i = 1'b0;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL l1_count got %0d exp 2", n);
    end
    checks++;
    if (a0 !== 1) begin
      errors++;
      $display("FAIL l1_first got %0d exp 1", a0);
    end
    checks++;
    if (a1 !== 3) begin
      errors++;
      $display("FAIL l1_second got %0d exp 3", a1);
    end
  endtask

  task automatic test_reset_mid();
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          n = 0;
    do_txn(1'b1, 32'h30, 32'h55AA55AA, err, rd, lat);
    @(negedge clk);
    bus_a.req_i   = 1'b1;
    bus_a.we_i    = 1'b1;
    bus_a.addr_i  = 32'h30;
    bus_a.wdata_i = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_busy got %b exp 0", bus_a.busy_o);
    end
    checks++;
    if (bus_a.ack_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_ack got %b exp 0", bus_a.ack_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_a.ack_o) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL rm_noack got %0d exp 0", n);
    end
    do_txn(1'b0, 32'h30, 32'h0, err, rd, lat);
    checks++;
    if (rd !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL rm_data got %h exp 55aa55aa", rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_latency1();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
